// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with registered read ports, optional write bypass and
// optional hardwired-zero entry 0. A clear sequencer zeroes every entry after reset.
module regfile_2r1w #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              WriteEn,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              ReadEnA,
  input  logic [ADDR_W-1:0] ReadAddrA,
  input  logic              ReadEnB,
  input  logic [ADDR_W-1:0] ReadAddrB,
  output logic [WIDTH-1:0]  OutA,
  output logic [WIDTH-1:0]  OutB,
  output logic              Ready
);

  localparam logic [ADDR_W:0]   DepthL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              wr_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  logic [ADDR_W-1:0] rd_addr [2];
  logic [WIDTH-1:0]  rd_data [2];

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LastIdx) state_d = StReady;
      end
      StReady: ;
      default: state_d = StClear;
    endcase
  end

  // A write counts only if it actually lands in storage; bypass keys off the same condition.
  always_comb begin
    wr_ok = (state_q == StReady) && WriteEn && ({1'b0, WriteAddr} < DepthL) &&
            !((ZERO_REG != 0) && (WriteAddr == '0));
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = WriteAddr;
    mem_wdata = data_i;
    if (!Rst) begin
      if (state_q == StClear) begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
      end else begin
        mem_we = wr_ok;
      end
    end
  end

  always_comb begin
    rd_addr[0] = ReadAddrA;
    rd_addr[1] = ReadAddrB;
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      if ({1'b0, rd_addr[p]} >= DepthL) begin
        rd_data[p] = '0;
      end else if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
      end else if ((BYPASS != 0) && wr_ok && (WriteAddr == rd_addr[p])) begin
        rd_data[p] = data_i;
      end else begin
        rd_data[p] = mem[rd_addr[p]];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Storage is deliberately left untouched by reset; the clear sequence handles it.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      OutA <= '0;
      OutB <= '0;
    end else if (state_q == StReady) begin
      if (ReadEnA) OutA <= rd_data[0];
      if (ReadEnB) OutB <= rd_data[1];
    end
  end

  assign Ready = (state_q == StReady);

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench: two configurations (32 deep with bypass, 20 deep without) share one
// stimulus stream; each step queues hand-computed expectations checked one edge later.
module tb_regfile_2r1w;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        WriteEn = 1'b0;
  logic [4:0]  WriteAddr = '0;
  logic [31:0] data_i = '0;
  logic        ReadEnA = 1'b0;
  logic [4:0]  ReadAddrA = '0;
  logic        ReadEnB = 1'b0;
  logic [4:0]  ReadAddrB = '0;

  logic [31:0] out_a0, out_b0, out_a1, out_b1;
  logic        ready0, ready1;

  always #5 Clk = ~Clk;

  regfile_2r1w #(
    .WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)
  ) u_dut0 (
    .Clk(Clk), .Rst(Rst), .WriteEn(WriteEn), .WriteAddr(WriteAddr), .data_i(data_i),
    .ReadEnA(ReadEnA), .ReadAddrA(ReadAddrA), .ReadEnB(ReadEnB), .ReadAddrB(ReadAddrB),
    .OutA(out_a0), .OutB(out_b0), .Ready(ready0)
  );

  regfile_2r1w #(
    .WIDTH(32), .DEPTH(20), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)
  ) u_dut1 (
    .Clk(Clk), .Rst(Rst), .WriteEn(WriteEn), .WriteAddr(WriteAddr), .data_i(data_i),
    .ReadEnA(ReadEnA), .ReadAddrA(ReadAddrA), .ReadEnB(ReadEnB), .ReadAddrB(ReadAddrB),
    .OutA(out_a1), .OutB(out_b1), .Ready(ready1)
  );

  typedef struct {
    int          tag;
    logic [31:0] a0, b0, a1, b1;
    logic        r0, r1;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h want %h", name, tag, act, exp);
    end
  endtask

  // One clock of stimulus; expectations describe the outputs right after the next edge.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic ena, input logic [4:0] aa,
                      input logic enb, input logic [4:0] ab,
                      input logic [31:0] xa0, input logic [31:0] xb0,
                      input logic [31:0] xa1, input logic [31:0] xb1,
                      input logic r0, input logic r1);
    exp_t e;
    @(negedge Clk);
    Rst = rst; WriteEn = we; WriteAddr = wa; data_i = wd;
    ReadEnA = ena; ReadAddrA = aa; ReadEnB = enb; ReadAddrB = ab;
    step_no++;
    e.tag = step_no;
    e.a0 = xa0; e.b0 = xb0; e.a1 = xa1; e.b1 = xb1; e.r0 = r0; e.r1 = r1;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("OutA_d32", e.tag, out_a0, e.a0);
        check("OutB_d32", e.tag, out_b0, e.b0);
        check("OutA_d20", e.tag, out_a1, e.a1);
        check("OutB_d20", e.tag, out_b1, e.b1);
        check("Ready_d32", e.tag, {31'b0, ready0}, {31'b0, e.r0});
        check("Ready_d20", e.tag, {31'b0, ready1}, {31'b0, e.r1});
      end
    end
  end

  initial begin : stimulus
    // Reset for two cycles.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Clear: writes and reads to addr 2 must be ignored while both files are clearing.
    for (int k = 1; k <= 32; k++) begin
      if (k <= 10)
        step(0, 1, 2, 32'h77, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0);
      else
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, k >= 32, k >= 20);
    end
    for (int i = 0; i < 32; i++)
      step(0, 0, 0, 0, 1, 5'(i), 1, 5'(31 - i), 0, 0, 0, 0, 1, 1);

    // Write then read, then hold with read strobes low.
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 5, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1);

    // Same-cycle write/read of addr 7: bypass in the 32-deep file, old value in the other.
    step(0, 1, 7, 32'h12345678, 1, 7, 1, 5,
         32'h12345678, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1, 1);
    step(0, 0, 0, 0, 1, 7, 1, 7, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 1, 1);

    // Entry 0 is hardwired to zero, including through the bypass.
    step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0,
         32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 1, 1);
    step(0, 0, 0, 0, 1, 0, 1, 7, 32'h0, 32'h12345678, 32'h0, 32'h12345678, 1, 1);
    step(0, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1);

    // Depth boundary: addr 25 and addr 20 exist only in the 32-deep file.
    step(0, 1, 25, 32'hAAAA5555, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 25, 1, 19, 32'hAAAA5555, 32'h0, 32'h0, 32'h0, 1, 1);
    step(0, 1, 19, 32'h13, 0, 0, 0, 0, 32'hAAAA5555, 32'h0, 32'h0, 32'h0, 1, 1);
    step(0, 0, 0, 0, 1, 19, 1, 25, 32'h13, 32'hAAAA5555, 32'h13, 32'h0, 1, 1);
    step(0, 1, 20, 32'h2020, 1, 20, 1, 20, 32'h2020, 32'h2020, 32'h0, 32'h0, 1, 1);
    step(0, 0, 0, 0, 1, 20, 1, 19, 32'h2020, 32'h13, 32'h0, 32'h13, 1, 1);
    // Ports are independent: only A reads, B holds.
    step(0, 0, 0, 0, 1, 5, 0, 7, 32'hDEADBEEF, 32'h13, 32'hDEADBEEF, 32'h13, 1, 1);

    // Reset mid-traffic while writing addr 3; the clear must wipe the earlier value too.
    step(0, 1, 3, 32'h33, 0, 0, 0, 0, 32'hDEADBEEF, 32'h13, 32'hDEADBEEF, 32'h13, 1, 1);
    step(0, 0, 0, 0, 1, 3, 0, 0, 32'h33, 32'h13, 32'h33, 32'h13, 1, 1);
    step(1, 1, 3, 32'h55, 1, 3, 1, 3, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 32; k++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, k >= 32, k >= 20);
    step(0, 0, 0, 0, 1, 3, 1, 5, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 7, 1, 2, 0, 0, 0, 0, 1, 1);

    @(negedge Clk);
    @(negedge Clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
